// File: rtl/nano_cache_mm_arbiter_if.sv
// Line-port bundle between the nano cache (instr + data miss ports), the
// arbiter and the shared single-port backing SRAM.
interface nano_cache_mm_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 8
);
    localparam int LW = LINE_WORDS * 32;
    localparam int SW = LINE_WORDS * 4;

    logic                  i_instr_rden;
    logic [ADDR_WIDTH-1:0] i_instr_addr;
    logic                  o_instr_gnt;
    logic                  o_instr_rvalid;
    logic [LW-1:0]         o_instr_rdata;

    logic                  i_data_rden;
    logic                  i_data_wren;
    logic [ADDR_WIDTH-1:0] i_data_addr;
    logic [LW-1:0]         i_data_wdata;
    logic [SW-1:0]         i_data_wstrb;
    logic                  o_data_gnt;
    logic                  o_data_rvalid;
    logic [LW-1:0]         o_data_rdata;

    logic                  o_sram_rden;
    logic                  o_sram_wren;
    logic [ADDR_WIDTH-1:0] o_sram_addr;
    logic [LW-1:0]         o_sram_wdata;
    logic [SW-1:0]         o_sram_wstrb;
    logic                  i_sram_gnt;
    logic                  i_sram_rvalid;
    logic [LW-1:0]         i_sram_rdata;

    logic                  o_owner;
    logic                  o_err_timeout;

    // arbiter side
    modport slave (
        input  i_instr_rden, i_instr_addr,
        output o_instr_gnt, o_instr_rvalid, o_instr_rdata,
        input  i_data_rden, i_data_wren, i_data_addr, i_data_wdata, i_data_wstrb,
        output o_data_gnt, o_data_rvalid, o_data_rdata,
        output o_sram_rden, o_sram_wren, o_sram_addr, o_sram_wdata, o_sram_wstrb,
        input  i_sram_gnt, i_sram_rvalid, i_sram_rdata,
        output o_owner, o_err_timeout
    );

    // environment side: cache requesters plus SRAM
    modport master (
        output i_instr_rden, i_instr_addr,
        input  o_instr_gnt, o_instr_rvalid, o_instr_rdata,
        output i_data_rden, i_data_wren, i_data_addr, i_data_wdata, i_data_wstrb,
        input  o_data_gnt, o_data_rvalid, o_data_rdata,
        input  o_sram_rden, o_sram_wren, o_sram_addr, o_sram_wdata, o_sram_wstrb,
        output i_sram_gnt, i_sram_rvalid, i_sram_rdata,
        input  o_owner, o_err_timeout
    );
endinterface

// File: rtl/nano_cache_mm_arbiter.sv
// Round-robin merge of the instr (read-only) and data (read/write) line ports
// onto one single-port SRAM line port, one transaction in flight, with a
// read-response watchdog.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's request
// REQ    | request held on the SRAM port until i_sram_gnt
// WAIT_R | read granted; wait for i_sram_rvalid or watchdog expiry
module nano_cache_mm_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    nano_cache_mm_arbiter_if.slave   bus
);
    localparam int LW    = LINE_WORDS * 32;
    localparam int SW    = LINE_WORDS * 4;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  rden_q, rden_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic instr_req, data_req, pick_data;

    assign instr_req = bus.i_instr_rden;
    assign data_req  = bus.i_data_rden | bus.i_data_wren;
    // On a tie the side that was not served last wins; last_q resets to data
    // so instr wins the first tie.
    assign pick_data = data_req & (~instr_req | ~last_q);

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: arbitration, grant handling and watchdog
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rden_d  = rden_q;
        wren_d  = wren_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (instr_req | data_req) begin
                    owner_d = pick_data;
                    last_d  = pick_data;
                    state_d = REQ;
                    if (pick_data) begin
                        // write wins if the requester raises both
                        wren_d  = bus.i_data_wren;
                        rden_d  = ~bus.i_data_wren;
                        addr_d  = bus.i_data_addr;
                        wdata_d = bus.i_data_wdata;
                        wstrb_d = bus.i_data_wstrb;
                    end else begin
                        wren_d  = 1'b0;
                        rden_d  = 1'b1;
                        addr_d  = bus.i_instr_addr;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            REQ: begin
                if (bus.i_sram_gnt) begin
                    rden_d  = 1'b0;
                    wren_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = rden_q ? WAIT_R : IDLE;
                end
            end
            WAIT_R: begin
                if (bus.i_sram_rvalid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants and read responses are steered to the owner combinationally
    assign bus.o_instr_gnt    = (state_q == REQ)    & bus.i_sram_gnt    & ~owner_q;
    assign bus.o_data_gnt     = (state_q == REQ)    & bus.i_sram_gnt    &  owner_q;
    assign bus.o_instr_rvalid = (state_q == WAIT_R) & bus.i_sram_rvalid & ~owner_q;
    assign bus.o_data_rvalid  = (state_q == WAIT_R) & bus.i_sram_rvalid &  owner_q;
    assign bus.o_instr_rdata  = (state_q == WAIT_R) ? bus.i_sram_rdata : '0;
    assign bus.o_data_rdata   = (state_q == WAIT_R) ? bus.i_sram_rdata : '0;

    assign bus.o_sram_rden   = rden_q;
    assign bus.o_sram_wren   = wren_q;
    assign bus.o_sram_addr   = addr_q;
    assign bus.o_sram_wdata  = wdata_q;
    assign bus.o_sram_wstrb  = wstrb_q;
    assign bus.o_owner       = owner_q;
    assign bus.o_err_timeout = err_q;
endmodule

// File: doc/nano_cache_mm_arbiter.md
Name: nano_cache_mm_arbiter

Overview:
- Merges the two line-wide miss/write-back ports of the nano cache (instr read-only, data read/write) onto one shared 256-bit line port of the backing SRAM.
- Sits directly downstream of the cache top. It replaces a dual-port SRAM with a single-port one.
- Arbitrates round-robin, allows one outstanding transaction, and routes grants and read data back to the owning side.
- Includes a read-response watchdog.

Parameters:
- ADDR_WIDTH, 32, line address width.
- LINE_WORDS, 8, 32-bit words per line. Line data width is LINE_WORDS*32; strobe width is LINE_WORDS*4.
- TIMEOUT, 1023, maximum cycles to wait in WAIT_R for i_sram_rvalid before flagging an error. Must be at least 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_instr_rden  in  1  instr line read request; held until granted
- i_instr_addr  in  ADDR_WIDTH  instr line address
- o_instr_gnt  out  1  instr request accepted (1-cycle pulse)
- o_instr_rvalid  out  1  instr read data valid (1-cycle pulse)
- o_instr_rdata  out  LINE_WORDS*32  instr read line
- i_data_rden  in  1  data line read request; held until granted
- i_data_wren  in  1  data line write request; held until granted
- i_data_addr  in  ADDR_WIDTH  data line address
- i_data_wdata  in  LINE_WORDS*32  write line
- i_data_wstrb  in  LINE_WORDS*4  byte strobes
- o_data_gnt  out  1  data request accepted (1-cycle pulse)
- o_data_rvalid  out  1  data read data valid (1-cycle pulse)
- o_data_rdata  out  LINE_WORDS*32  data read line
- o_sram_rden  out  1  shared port read request
- o_sram_wren  out  1  shared port write request
- o_sram_addr  out  ADDR_WIDTH  shared port address
- o_sram_wdata  out  LINE_WORDS*32  shared port write line
- o_sram_wstrb  out  LINE_WORDS*4  shared port strobes
- i_sram_gnt  in  1  SRAM accepted request
- i_sram_rvalid  in  1  SRAM read data valid
- i_sram_rdata  in  LINE_WORDS*32  SRAM read line
- o_owner  out  1  current owner (0=instr, 1=data); debug
- o_err_timeout  out  1  sticky watchdog flag

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
  - On reset: state IDLE; last_owner=1 (instr wins the first tie); o_owner=0; o_err_timeout=0; watchdog counter=0.
  - All request and strobe outputs are registered zeros. o_sram_addr, wdata and wstrb are 0.
  - Reset mid-transaction abandons it. A late i_sram_rvalid after reset is ignored (state is IDLE).
- State IDLE: outputs idle.
  - Candidates: instr = i_instr_rden; data = i_data_rden | i_data_wren.
  - If both request, pick the side that is not last_owner. Otherwise pick the single requester.
  - On selection: register owner, rden/wren, addr, wdata, wstrb into the o_sram_* regs; set last_owner=owner; go to REQ.
  - Instr requests always issue with wdata=0 and wstrb=0.
  - If i_data_rden and i_data_wren are both set, the write takes precedence and the read is ignored (requester protocol violation).
- State REQ: o_sram_rden/o_sram_wren and payload are held stable until i_sram_gnt.
  - On the gnt cycle: o_instr_gnt or o_data_gnt = i_sram_gnt & (owner matches), combinational pass-through, same cycle.
  - Next cycle the o_sram_rden/o_sram_wren regs clear; next state is WAIT_R for a read, IDLE for a write.
  - A write is complete at gnt; there is no response.
- State WAIT_R: o_<owner>_rvalid = i_sram_rvalid, combinational.
  - i_sram_rdata is broadcast to both o_*_rdata; only the owner's rvalid asserts.
  - On rvalid: go to IDLE and clear the counter.
  - The counter increments every cycle without rvalid. When it reaches TIMEOUT: set o_err_timeout (sticky until reset), go to IDLE, and emit no rvalid.
- Minimum spacing: IDLE→REQ costs one cycle, so back-to-back transactions are at least 2 cycles apart for writes and at least 3 for reads. The requester drops its request the cycle after gnt. A request re-asserted in IDLE is arbitrated normally.
- Ignored inputs: i_sram_gnt outside REQ and i_sram_rvalid outside WAIT_R have no effect.
- Simultaneous gnt+rvalid: gnt in REQ is handled; rvalid is ignored because the state is not yet WAIT_R. The SRAM must return rvalid no earlier than one cycle after gnt.
- o_owner updates on every IDLE→REQ transition and holds otherwise.

Test Plan:
- Single instr read:
  - Stimulus: i_instr_rden=1, addr=0x100. SRAM gnt at REQ cycle 2; rvalid 3 cycles later with rdata word0=0xDEADBEEF.
  - Required: o_sram_rden=1, addr=0x100; one o_instr_gnt pulse; o_instr_rvalid with word0=0xDEADBEEF; o_data_rvalid=0 throughout.
- Data write:
  - Stimulus: i_data_wren=1, addr=0x200, wstrb=all-ones, gnt immediate.
  - Required: o_sram_wren=1 with matching wdata/wstrb; o_data_gnt in the same cycle; IDLE next cycle; no rvalid.
- Simultaneous requests after reset:
  - Stimulus: instr read and data read both held.
  - Required: instr served first (o_owner=0), then data (o_owner=1). Repeat the same scenario: order alternates.
- Timeout (TIMEOUT=4):
  - Stimulus: data read granted, rvalid never arrives.
  - Required: o_err_timeout=1 after 4 WAIT_R cycles; next request accepted; flag stays set until i_rst.
- Reset in WAIT_R:
  - Stimulus: i_rst asserted, then a stray i_sram_rvalid.
  - Required: all outputs 0; no o_*_rvalid produced.
- Spurious handshakes:
  - Stimulus: i_sram_gnt or i_sram_rvalid pulsed in IDLE.
  - Required: no grant, rvalid, or state change.
